cordic_vector_iter: RTL

CORDIC_VECTOR_ITER -- requirements
Module: cordic_vector_iter

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_vector_iter_gain_comp.sv | 24 ++
 rtl/cordic_vector_iter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared types, widths and helpers for the iterative CORDIC
//               vectoring block (state enum, port widths, gain-compensation
//               shift amounts, angle wrap helper).
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int K_W   = 5;
  localparam int LUT_W = 10;

  // 1/1.6468 ~= 2^-1 + 2^-3 - 2^-6 - 2^-9
  localparam int GC_SH_A = 1;
  localparam int GC_SH_B = 3;
  localparam int GC_SH_C = 6;
  localparam int GC_SH_D = 9;

  localparam logic signed [LUT_W-1:0] DEG_90  = 10'sd90;
  localparam logic signed [LUT_W-1:0] DEG_180 = 10'sd180;
  localparam logic signed [LUT_W-1:0] DEG_360 = 10'sd360;

  // Fold an accumulated angle back into -180..180 degrees.
  function automatic logic signed [LUT_W-1:0] wrap_deg(input logic signed [LUT_W-1:0] d);
    logic signed [LUT_W-1:0] r;
    r = d;
    if (d > DEG_180)
      r = d - DEG_360;
    else if (d < -DEG_180)
      r = d + DEG_360;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vector_iter_gain_comp.sv
`default_nettype none
// ============================================================================
// Module      : cordic_gain_comp
// Description : Shift-add multiply of the raw CORDIC magnitude by ~0.6073 to
//               remove the accumulated rotation gain. Only instantiated when
//               CORDIC_GAIN_COMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int XW = 18
) (
  input  logic [XW-1:0] i_x,
  output logic [XW-1:0] o_mag
);

  // Magnitude is always non-negative, so logical shifts are exact here and
  // the positive terms always dominate the subtracted ones.
  assign o_mag = (i_x >> GC_SH_A) + (i_x >> GC_SH_B)
               - (i_x >> GC_SH_C) - (i_x >> GC_SH_D);

endmodule
`default_nettype wire

// File: rtl/cordic_vector_iter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vector_iter
// Description : Iterative CORDIC in vectoring mode. Accepts a signed (x,y)
//               vector, performs one micro-rotation per clock using an
//               external arctangent table addressed by k, and returns the
//               angle in whole degrees and the magnitude.
//               Optional macro CORDIC_GAIN_COMP_EN adds a COMP cycle that
//               scales the magnitude by ~0.6073.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 20,
  parameter int DW         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    x_in,
  input  logic signed [DW-1:0]    y_in,
  output logic [K_W-1:0]          k,
  input  logic [LUT_W-1:0]        lut_k,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [LUT_W-1:0] angle_out,
  output logic [DW+1:0]           mag_out
);

  // Two guard bits: negating -2^(DW-1) and the ~1.65 gain both fit.
  localparam int XW = DW + 2;

  state_t                  r_state;
  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic signed [LUT_W-1:0] r_z;
  logic                    r_zero;
  logic [K_W-1:0]          r_k;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [LUT_W-1:0] r_angle;
  logic [XW-1:0]           r_mag;

  logic signed [XW-1:0]    w_x_ext;
  logic signed [XW-1:0]    w_y_ext;
  logic signed [XW-1:0]    w_x_pre;
  logic signed [XW-1:0]    w_y_pre;
  logic signed [LUT_W-1:0] w_z_pre;
  logic signed [XW-1:0]    w_x_nxt;
  logic signed [XW-1:0]    w_y_nxt;
  logic signed [LUT_W-1:0] w_z_nxt;
  logic signed [LUT_W-1:0] w_lut;
  logic                    w_last;

  assign w_x_ext = {{2{x_in[DW-1]}}, x_in};
  assign w_y_ext = {{2{y_in[DW-1]}}, y_in};
  assign w_lut   = signed'(lut_k);
  assign w_last  = (r_k == K_W'(ITERATIONS - 1));

  assign in_ready  = r_in_ready;
  assign k         = r_k;
  assign out_valid = r_out_valid;
  assign angle_out = r_angle;
  assign mag_out   = r_mag;

`ifdef CORDIC_GAIN_COMP_EN
  logic [XW-1:0] w_mag_comp;

  cordic_gain_comp #(
    .XW (XW)
  ) u_gain_comp (
    .i_x   ($unsigned(r_x)),
    .o_mag (w_mag_comp)
  );
`endif

  // Rotate left-half-plane inputs by +/-90 degrees into the convergence range.
  always_comb begin
    w_x_pre = w_x_ext;
    w_y_pre = w_y_ext;
    w_z_pre = '0;
    if (x_in[DW-1]) begin
      if (!y_in[DW-1]) begin
        w_x_pre = w_y_ext;
        w_y_pre = -w_x_ext;
        w_z_pre = DEG_90;
      end else begin
        w_x_pre = -w_y_ext;
        w_y_pre = w_x_ext;
        w_z_pre = -DEG_90;
      end
    end
  end

  // One micro-rotation driving y toward zero, using pre-update x and y.
  always_comb begin
    if (!r_y[XW-1]) begin
      w_x_nxt = r_x + (r_y >>> r_k);
      w_y_nxt = r_y - (r_x >>> r_k);
      w_z_nxt = r_z + w_lut;
    end else begin
      w_x_nxt = r_x - (r_y >>> r_k);
      w_y_nxt = r_y + (r_x >>> r_k);
      w_z_nxt = r_z - w_lut;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_zero      <= 1'b0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_angle     <= '0;
      r_mag       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= w_x_pre;
            r_y        <= w_y_pre;
            r_z        <= w_z_pre;
            // A zero vector has no direction; force its angle to 0.
            r_zero     <= (x_in == '0) && (y_in == '0);
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ITER;
          end
        end
        ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (w_last) begin
            r_k <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            r_state <= COMP;
`else
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_angle     <= r_zero ? '0 : wrap_deg(w_z_nxt);
            r_mag       <= $unsigned(w_x_nxt);
`endif
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_angle     <= r_zero ? '0 : wrap_deg(r_z);
          r_mag       <= w_mag_comp;
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
